// File: rtl/data_port_master.sv
// CPU-side initiator for the word-wide data memory bus: sub-word loads/stores with
// byte-reversed memory words and read-modify-write for partial stores.
module data_port_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        busy,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        st_done,
  output logic        addr_error,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        store_q, signed_q, addr_error_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q, rd_data_q;
  logic        op_err;
  logic [31:0] lane_shift, load_val, merged;
  logic [15:0] half_val;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb begin
    op_err = 1'b0;
    unique case (op_size)
      2'b00:   op_err = 1'b0;
      2'b01:   op_err = op_addr[0];
      2'b10:   op_err = |op_addr[1:0];
      default: op_err = 1'b1;
    endcase
  end

  // Load extraction straight off the bus so rd_data is ready by RESP.
  always_comb begin
    lane_shift = data_readdata >> {addr_q[1:0], 3'b000};
    half_val   = addr_q[1] ? {data_readdata[23:16], data_readdata[31:24]}
                           : {data_readdata[7:0], data_readdata[15:8]};
    unique case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_shift[7]}}, lane_shift[7:0]};
      2'b01:   load_val = {{16{signed_q & half_val[15]}}, half_val};
      default: load_val = bswap(data_readdata);
    endcase
  end

  // Big-endian half: the byte at the lower address takes the high half of the store data.
  always_comb begin
    merged = word_q;
    unique case (size_q)
      2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) begin
          merged[23:16] = wdata_q[15:8];
          merged[31:24] = wdata_q[7:0];
        end else begin
          merged[7:0]   = wdata_q[15:8];
          merged[15:8]  = wdata_q[7:0];
        end
      end
      default: merged = bswap(wdata_q);
    endcase
  end

  always_comb begin
    state_d        = state_q;
    busy           = (state_q != StIdle);
    data_read      = 1'b0;
    data_write     = 1'b0;
    data_writedata = '0;
    rd_valid       = 1'b0;
    st_done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid && !op_err) begin
          state_d = (op_store && op_size == 2'b10) ? StWr : StRd;
        end
      end
      StRd: begin
        data_read = 1'b1;
        state_d   = store_q ? StWr : StResp;
      end
      StWr: begin
        data_write     = 1'b1;
        data_writedata = merged;
        state_d        = StResp;
      end
      StResp: begin
        rd_valid = !store_q;
        st_done  = store_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      store_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      rd_data_q    <= '0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_error_q <= 1'b0;
      if (state_q == StIdle && op_valid) begin
        store_q      <= op_store;
        size_q       <= op_size;
        signed_q     <= op_signed;
        addr_q       <= op_addr;
        wdata_q      <= op_wdata;
        addr_error_q <= op_err;
      end
      if (state_q == StRd) begin
        word_q <= data_readdata;
        if (!store_q) rd_data_q <= load_val;
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign addr_error   = addr_error_q;
  assign data_address = {addr_q[31:2], 2'b00};

endmodule

// File: doc/data_port_master.md
# data_port_master

CPU-side initiator for the word-wide data memory port. It turns MIPS load/store requests into transactions on the single-cycle data bus (data_address / data_read / data_write / data_writedata / data_readdata), and the data memory responds on that bus. The block handles:
- byte, halfword and word sizes;
- sign/zero extension;
- alignment checking;
- the byte-reversed memory word format;
- read-modify-write for sub-word stores, because the bus has no byte enables.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  request present; sampled only in IDLE
- op_store  in  1  1 = store, 0 = load
- op_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as addr error)
- op_signed  in  1  sign-extend loads (byte/half); ignored for word and stores
- op_addr  in  32  byte address
- op_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- busy  out  1  high whenever state != IDLE
- rd_valid  out  1  one-cycle pulse, load result valid
- rd_data  out  32  load result, held until next load response
- st_done  out  1  one-cycle pulse, store committed
- addr_error  out  1  one-cycle pulse, misaligned/reserved request rejected
- data_address  out  32  word-aligned bus address, bits [1:0] always 00
- data_read  out  1  bus read strobe
- data_write  out  1  bus write strobe
- data_writedata  out  32  bus write data, memory byte order
- data_readdata  in  32  bus read data, combinational from data_address

## Operation
Memory byte order:
- The byte at address 4k+i sits in bus bits [8i+7:8i].
- A CPU word value is therefore byte-reversed: word = {bus[7:0], bus[15:8], bus[23:16], bus[31:24]}.

Load extraction, where off = addr[1:0]:
- Byte: bus[8·off+7 : 8·off].
- Half at off 0: {bus[7:0], bus[15:8]}.
- Half at off 2: {bus[23:16], bus[31:24]}.
- Result is sign- or zero-extended per op_signed.

Stores:
- Word store: writedata = byte-reverse(op_wdata).
- Byte store: the word is read, then lane off is replaced with op_wdata[7:0].
- Half store: the word is read, then lanes off and off+1 are replaced with op_wdata[15:8] and op_wdata[7:0] respectively (big-endian).

Alignment:
- Half requires addr[0]=0; word requires addr[1:0]=00; op_size=11 is always an error.
- On violation: addr_error pulses the cycle after acceptance and the FSM stays in IDLE.
- No bus strobe is issued for a rejected request.

FSM states: IDLE, RD, WR, RESP.
- IDLE: if op_valid, register the op. Error goes to IDLE (addr_error pulse). Word store goes to WR. Everything else goes to RD.
- RD: data_read=1. data_readdata is captured into the word register at the clock edge. Load goes to RESP; sub-word store goes to WR.
- WR: data_write=1, with merged or reversed data on data_writedata. Goes to RESP.
- RESP: rd_valid=1 (load) or st_done=1 (store). Goes to IDLE.

Invariants:
- data_read and data_write are never high together.
- Both strobes are low in IDLE and RESP.
- data_address = {addr_q[31:2], 2'b00} at all times.
- op_valid while busy is ignored; the requester must hold the request until busy is low.

## Timing
Acceptance edge = T0.
- Load: RD in T0–T1, RESP (rd_valid) in T1–T2. The next request can be accepted at edge T2.
- Word store: WR in T0–T1, where memory writes at edge T1; then RESP (st_done).
- Sub-word store: RD, then WR, then RESP. Memory writes at edge T2; st_done is high during T2–T3.

Reset values: busy 0, rd_valid 0, rd_data 0, st_done 0, addr_error 0, data_address 0, data_read 0, data_write 0, data_writedata 0. The FSM resets to IDLE.

Reset mid-operation:
- Reset high at an edge while in WR: that write still commits, because the memory samples the same edge.
- The FSM is in IDLE the next cycle, and no response pulse is generated.
- Reset while in RD or RESP: the op is dropped and no bus write ever occurs.

Back-to-back: a store followed by a load to the same word returns the stored data. The write commits before the RD cycle of the next op.

## Test plan
- Reset, then idle for 3 cycles: all outputs 0 and no strobes.
- Word store 32'h12345678 to 0x10, then word load from 0x10:
  - bus write of 32'h78563412 at data_address 0x10;
  - rd_data = 32'h12345678 two cycles after acceptance.
- Memory word 32'h00000080 preloaded at 0x20 (byte 0x20 = 8'h80):
  - LB 0x20 returns 32'hFFFFFF80;
  - LBU 0x20 returns 32'h00000080;
  - LH 0x22 returns 0.
- SB 8'hAB to 0x33 over word 32'h11223344 (bus form):
  - one RD, then WR of 32'hAB223344;
  - st_done 3 cycles after acceptance.
- LH 0x41, or LW 0x42, or op_size=11:
  - addr_error pulse;
  - no data_read/data_write;
  - busy stays 0.
- Sub-word store with reset asserted during RD:
  - no data_write ever;
  - memory unchanged;
  - FSM IDLE and accepting a new op two cycles later.
